// File: rtl/spi_dac_pkg.sv
// Shared definitions for the SPI DAC receiver: FSM states, command encodings
// and the layout of the control field.
package spi_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CTRL   = 2'd1,
        ST_DATA   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_WRITE_UPDATE = 2'b00,
        CMD_WRITE_INPUT  = 2'b01,
        CMD_UPDATE_ALL   = 2'b10,
        CMD_READBACK     = 2'b11
    } cmd_t;

    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 4;
    localparam int CMD_LSB  = 4;
    localparam int CMD_W    = 2;

    typedef struct packed {
        cmd_t              cmd;
        logic [ADDR_W-1:0] addr;
    } ctrl_t;

    // Only the low six bits of the control field carry meaning.
    function automatic ctrl_t decode_ctrl(input logic [5:0] field);
        ctrl_t c;
        c.cmd  = cmd_t'(field[CMD_LSB +: CMD_W]);
        c.addr = field[ADDR_LSB +: ADDR_W];
        return c;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous input, followed by a history
// flop that yields single-cycle rise/fall pulses in the clk domain.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: sequential state always uses non-blocking assignments so that every
    // flop samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_dac_rx.sv
// SPI slave feeding a bank of double-buffered DAC registers, with readback of
// the active DAC value over SDO.
module spi_dac_rx
    import spi_dac_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int CTRL_W     = 8,
    parameter int NUM_CH     = 4,
    parameter int OFFSET_BIN = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     SCK,
    input  logic                     SDI,
    input  logic                     CS_,
    output logic                     SDO,
    output logic [NUM_CH*DATA_W-1:0] dac_out,
    output logic [NUM_CH-1:0]        update_stb,
    output logic                     frame_err
);

    localparam int FL    = CTRL_W + DATA_W;
    localparam int CNT_W = $clog2(FL + 1);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [ADDR_W:0]   CH_LIMIT = (ADDR_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0]  CNT_CTRL = CNT_W'(CTRL_W);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FL);
    localparam logic [DATA_W-1:0] MSB_MASK =
        (OFFSET_BIN != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    logic sck_s, sck_rise, sck_fall;
    logic sdi_s, sdi_rise, sdi_fall;
    logic cs_s,  cs_rise,  cs_fall;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .reset(reset), .din(SCK), .sync(sck_s), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .reset(reset), .din(SDI), .sync(sdi_s), .rise(sdi_rise), .fall(sdi_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .din(CS_), .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    state_t             state, state_nxt;
    logic               frame_start;
    logic               enter_data;
    logic               sampling;

    logic [FL-1:0]      shift_in;
    logic [CNT_W-1:0]   bit_cnt;
    logic               overrun;

    logic [DATA_W-1:0]  input_reg [NUM_CH];
    logic [DATA_W-1:0]  dac_reg   [NUM_CH];

    logic [DATA_W-1:0]  rb_shift;
    logic               rb_active;

    // Header as seen once the control bits are in, and as seen after a full frame.
    logic [CTRL_W-1:0]  hdr_early, hdr_full;
    logic [DATA_W-1:0]  data_full;
    ctrl_t              ctl_early, ctl_full;
    logic [IDX_W-1:0]   idx_early, idx_full;
    logic               addr_ok_early, addr_ok_full;
    logic               frame_ok;

    assign hdr_early     = shift_in[CTRL_W-1:0];
    assign hdr_full      = shift_in[FL-1 -: CTRL_W];
    assign data_full     = shift_in[DATA_W-1:0];
    assign ctl_early     = decode_ctrl(hdr_early[5:0]);
    assign ctl_full      = decode_ctrl(hdr_full[5:0]);
    assign idx_early     = ctl_early.addr[IDX_W-1:0];
    assign idx_full      = ctl_full.addr[IDX_W-1:0];
    assign addr_ok_early = ({1'b0, ctl_early.addr} < CH_LIMIT);
    assign addr_ok_full  = ({1'b0, ctl_full.addr} < CH_LIMIT);
    assign frame_ok      = (bit_cnt == CNT_FULL) && !overrun &&
                           ((ctl_full.cmd == CMD_UPDATE_ALL) || addr_ok_full);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_nxt   = state;
        frame_start = 1'b0;
        enter_data  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_nxt   = ST_CTRL;
                    frame_start = 1'b1;
                end
            end
            ST_CTRL: begin
                if (cs_rise) begin
                    state_nxt = ST_COMMIT;
                end else if (bit_cnt == CNT_CTRL) begin
                    state_nxt  = ST_DATA;
                    enter_data = 1'b1;
                end
            end
            ST_DATA: begin
                if (cs_rise) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                // A new frame may already have begun; it starts right after this commit.
                state_nxt = ST_IDLE;
                if (cs_fall) begin
                    state_nxt   = ST_CTRL;
                    frame_start = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign sampling = ((state == ST_CTRL) || (state == ST_DATA)) && !cs_s && sck_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_in <= '0;
            bit_cnt  <= '0;
            overrun  <= 1'b0;
        end else if (frame_start) begin
            shift_in <= '0;
            bit_cnt  <= '0;
            overrun  <= 1'b0;
        end else if (sampling) begin
            if (bit_cnt == CNT_FULL) begin
                overrun <= 1'b1;
            end else begin
                shift_in <= {shift_in[FL-2:0], sdi_s};
                bit_cnt  <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: the register file is cleared on reset because its contents drive the
    // DAC pins directly; a storage array without that need would skip the reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                input_reg[k] <= '0;
                dac_reg[k]   <= '0;
            end
            update_stb <= '0;
            frame_err  <= 1'b0;
        end else begin
            update_stb <= '0;
            frame_err  <= 1'b0;
            if (state == ST_COMMIT) begin
                if (!frame_ok) begin
                    frame_err <= 1'b1;
                end else begin
                    case (ctl_full.cmd)
                        CMD_WRITE_UPDATE: begin
                            input_reg[idx_full]  <= data_full;
                            dac_reg[idx_full]    <= data_full;
                            update_stb[idx_full] <= 1'b1;
                        end
                        CMD_WRITE_INPUT: begin
                            input_reg[idx_full] <= data_full;
                        end
                        CMD_UPDATE_ALL: begin
                            for (int k = 0; k < NUM_CH; k++) dac_reg[k] <= input_reg[k];
                            update_stb <= '1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Readback: the MSB is presented as soon as the header is known; shifting
    // starts only after the first data bit has been sampled, so the master sees
    // bit DATA_W-1 on the first data-phase rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rb_shift  <= '0;
            rb_active <= 1'b0;
        end else if (enter_data) begin
            if ((ctl_early.cmd == CMD_READBACK) && addr_ok_early) begin
                rb_shift  <= dac_reg[idx_early];
                rb_active <= 1'b1;
            end else begin
                rb_shift  <= '0;
                rb_active <= 1'b0;
            end
        end else if (state != ST_DATA) begin
            rb_shift  <= '0;
            rb_active <= 1'b0;
        end else if (sck_fall && !cs_s && (bit_cnt > CNT_CTRL)) begin
            rb_shift <= {rb_shift[DATA_W-2:0], 1'b0};
        end
    end

    assign SDO = rb_active & rb_shift[DATA_W-1];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_dac_out
        assign dac_out[k*DATA_W +: DATA_W] = dac_reg[k] ^ MSB_MASK;
    end

    logic unused_sig;
    assign unused_sig = ^{sck_s, sdi_rise, sdi_fall, hdr_early, hdr_full};

endmodule
